time_counter_bcd: RTL and testbench
===================================

Name: time_counter_bcd

Overview:
- Parametrised successor to the minute/hour counting logic: a time-of-day counter that advances on a single-cycle tick enable.
- Adds an optional seconds field, runtime 12/24-hour display mode, load validation, and a day-rollover pulse.
- Drives the BCD display bus consumed by the display driver and the alarm comparator.
- Sits between the tick generator (one_sec or one_minute) and the display/alarm logic.

Parameters:
- WITH_SEC, 1: 1 = seconds field present and tick advances seconds; 0 = no seconds field and tick advances minutes.
- DISP_W, derived localparam (WITH_SEC ? 24 : 16): display bus width, 4 bits per BCD digit.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- tick  in  1  single-cycle advance enable (one second or one minute, per WITH_SEC).
- load  in  1  single-cycle request to load a new time.
- load_hr  in  5  hour to load, binary 0..23.
- load_min  in  6  minute to load, binary 0..59.
- load_sec  in  6  second to load, binary 0..59; ignored when WITH_SEC=0.
- mode_12h  in  1  display mode: 1 = 12-hour, 0 = 24-hour. Affects display only, never stored time.
- disp  out  DISP_W  BCD digits, MSB first: HH MM [SS].
- pm  out  1  1 when stored hour >= 12, in either mode.
- rollover  out  1  one-cycle pulse on the 23:59[:59] -> 00:00[:00] wrap.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- State: registered binary hr (5b), min (6b) and sec (6b, only when WITH_SEC=1). Time is always stored in 24-hour form.
- Reset (reset_n=0 at a clk edge): hr=min=sec=0, rollover=0, load_err=0. Result: disp = all zeros, pm=0. Reset has priority over load and tick.
- Priority per edge: reset_n low > load > tick. When load and tick are both high, the loaded value is stored exactly and the tick is dropped.
- Valid load (hr<=23, min<=59, and sec<=59 when WITH_SEC=1): state takes the loaded values at that edge; load_err=0.
- Invalid load: state unchanged; tick in the same cycle is also dropped; load_err=1 for the next cycle only.
- Tick, WITH_SEC=1: sec increments. At 59 it wraps to 0 and carries to min. min at 59 wraps to 0 and carries to hr. hr at 23 wraps to 0.
- Tick, WITH_SEC=0: same carry chain starting at min.
- rollover: registered. High for exactly the one cycle after the edge where all fields wrapped to 0. A load to 00:00:00 never raises rollover.
- disp: combinational from the state registers, so it reflects the new time in the same cycle the state updates (zero added latency).
- Hour display, 24-hour mode: hour shown as-is.
- Hour display, 12-hour mode: 0 -> 12; 1..12 -> unchanged; 13..23 -> hr-12.
- Each field is converted binary -> 2-digit BCD; tens digit in the upper nibble. No blanking of a leading zero (01 shows as 0,1).
- Toggling mode_12h changes disp immediately and never alters state.
- Back-to-back ticks on consecutive cycles are legal; each one advances state once.

Decomposition:
- Package time_pkg:
  - MAX_HR=23, MAX_MIN=59, MAX_SEC=59.
  - Field widths HR_W=5, MS_W=6.
  - Function to_12h(hr) returning the display hour.
- Sub-module bin2bcd2: combinational, 6-bit binary 0..59 in -> 8-bit BCD out. Instantiated once per field (hour goes through to_12h first).

Test Plan:
- Reset, WITH_SEC=0: reset_n low one edge -> disp=0000, pm=0, rollover=0.
- WITH_SEC=0, then 1441 ticks -> after tick 1440, disp=0000 and rollover pulses exactly once. After tick 1441, disp=0001.
- WITH_SEC=0, load 11:45 then 121 ticks -> disp=1346 in 24-hour mode. Set mode_12h=1 -> disp=0146 and pm=1, with no state change.
- WITH_SEC=1, load 23:59:58, then 2 ticks -> disp=235959, then 000000, with rollover pulsing one cycle after the second tick.
- Load hr=24 min=10 together with tick, from state 05:00 -> state stays 05:00, load_err pulses, tick is dropped. Next: valid load 07:30 with tick in the same cycle -> 07:30.
- Mid-run reset: from state 12:34, assert reset_n low together with load and tick -> 00:00, pm=0, no load_err and no rollover.

Source files
------------

// File: rtl/time_counter_bcd_pkg.sv
// Shared limits, field widths and 12-hour display mapping for the
// time-of-day counter.
package time_pkg;

  localparam int HR_W = 5;
  localparam int MS_W = 6;

  localparam logic [HR_W-1:0] MAX_HR  = 5'd23;
  localparam logic [MS_W-1:0] MAX_MIN = 6'd59;
  localparam logic [MS_W-1:0] MAX_SEC = 6'd59;

  // Stored 24-hour value -> 12-hour display value (0 shows as 12).
  function automatic logic [HR_W-1:0] to_12h(input logic [HR_W-1:0] hr);
    logic [HR_W-1:0] res;
    if (hr == 5'd0) begin
      res = 5'd12;
    end else if (hr > 5'd12) begin
      res = hr - 5'd12;
    end else begin
      res = hr;
    end
    return res;
  endfunction

endpackage

// File: rtl/time_counter_bcd_bin2bcd2.sv
// Combinational binary (0..59) to two-digit BCD, tens digit in the upper nibble.
module bin2bcd2
  import time_pkg::*;
(
  input  logic [MS_W-1:0] bin_i,
  output logic [7:0]      bcd_o
);

  logic [3:0] tens_s;
  logic [3:0] ones_s;

  // Subtract the largest multiple of ten; inputs never exceed 59.
  always_comb begin
    tens_s = 4'd0;
    ones_s = 4'(bin_i);
    if (bin_i >= 6'd50) begin
      tens_s = 4'd5;
      ones_s = 4'(bin_i - 6'd50);
    end else if (bin_i >= 6'd40) begin
      tens_s = 4'd4;
      ones_s = 4'(bin_i - 6'd40);
    end else if (bin_i >= 6'd30) begin
      tens_s = 4'd3;
      ones_s = 4'(bin_i - 6'd30);
    end else if (bin_i >= 6'd20) begin
      tens_s = 4'd2;
      ones_s = 4'(bin_i - 6'd20);
    end else if (bin_i >= 6'd10) begin
      tens_s = 4'd1;
      ones_s = 4'(bin_i - 6'd10);
    end else begin
      tens_s = 4'd0;
      ones_s = 4'(bin_i);
    end
  end

  assign bcd_o = {tens_s, ones_s};

endmodule

// File: rtl/time_counter_bcd.sv
// Time-of-day counter: binary 24-hour state advanced by a tick, validated
// loads, day-rollover pulse and a BCD display bus with optional 12-hour view.
module time_counter_bcd
  import time_pkg::*;
#(
  parameter int WITH_SEC = 1,
  localparam int DISP_W = (WITH_SEC != 0) ? 24 : 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              load,
  input  logic [HR_W-1:0]   load_hr,
  input  logic [MS_W-1:0]   load_min,
  input  logic [MS_W-1:0]   load_sec,
  input  logic              mode_12h,
  output logic [DISP_W-1:0] disp,
  output logic              pm,
  output logic              rollover,
  output logic              load_err
);

  logic [HR_W-1:0] hr_q,  hr_d;
  logic [MS_W-1:0] min_q, min_d;
  logic [MS_W-1:0] sec_q, sec_d;
  logic            roll_q, roll_d;
  logic            err_q, err_d;

  logic load_ok_s;
  logic sec_wrap_s;

  assign load_ok_s  = (load_hr <= MAX_HR) && (load_min <= MAX_MIN) &&
                      ((WITH_SEC == 0) || (load_sec <= MAX_SEC));
  // Without a seconds field every tick carries straight into minutes.
  assign sec_wrap_s = (WITH_SEC == 0) || (sec_q == MAX_SEC);

  // Next-state: load beats tick; a rejected load also swallows the tick.
  always_comb begin
    hr_d   = hr_q;
    min_d  = min_q;
    sec_d  = sec_q;
    roll_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        hr_d  = load_hr;
        min_d = load_min;
        sec_d = (WITH_SEC != 0) ? load_sec : 6'd0;
      end else begin
        err_d = 1'b1;
      end
    end else if (tick) begin
      if (!sec_wrap_s) begin
        sec_d = sec_q + 6'd1;
      end else begin
        sec_d = 6'd0;
        if (min_q == MAX_MIN) begin
          min_d = 6'd0;
          if (hr_q == MAX_HR) begin
            hr_d   = 5'd0;
            roll_d = 1'b1;
          end else begin
            hr_d = hr_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end
    end else begin
      hr_d = hr_q;
    end
  end

  // State and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hr_q   <= 5'd0;
      min_q  <= 6'd0;
      sec_q  <= 6'd0;
      roll_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hr_q   <= hr_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
      roll_q <= roll_d;
      err_q  <= err_d;
    end
  end

  assign rollover = roll_q;
  assign load_err = err_q;
  assign pm       = (hr_q >= 5'd12);

  logic [HR_W-1:0] hr_disp_s;
  logic [7:0]      hr_bcd_s;
  logic [7:0]      min_bcd_s;

  assign hr_disp_s = mode_12h ? to_12h(hr_q) : hr_q;

  bin2bcd2 u_hr_bcd  (.bin_i({1'b0, hr_disp_s}), .bcd_o(hr_bcd_s));
  bin2bcd2 u_min_bcd (.bin_i(min_q),             .bcd_o(min_bcd_s));

  if (WITH_SEC != 0) begin : g_sec
    logic [7:0] sec_bcd_s;
    bin2bcd2 u_sec_bcd (.bin_i(sec_q), .bcd_o(sec_bcd_s));
    assign disp = {hr_bcd_s, min_bcd_s, sec_bcd_s};
  end else begin : g_nosec
    assign disp = {hr_bcd_s, min_bcd_s};
  end

endmodule

// File: tb/tb_time_counter_bcd.sv
// Directed bench for time_counter_bcd: one instance without and one with seconds.
module tb_time_counter_bcd;

  logic        clk;
  logic        reset_n;
  logic        tick;
  logic        load;
  logic [4:0]  load_hr;
  logic [5:0]  load_min;
  logic [5:0]  load_sec;
  logic        mode_12h;
  logic [15:0] disp0;
  logic        pm0, roll0, err0;
  logic [23:0] disp1;
  logic        pm1, roll1, err1;

  int errors = 0;
  int checks = 0;

  time_counter_bcd #(.WITH_SEC(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .load(load),
    .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
    .mode_12h(mode_12h), .disp(disp0), .pm(pm0), .rollover(roll0),
    .load_err(err0)
  );

  time_counter_bcd #(.WITH_SEC(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .load(load),
    .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
    .mode_12h(mode_12h), .disp(disp1), .pm(pm1), .rollover(roll1),
    .load_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        ld;
    logic [4:0]  hr;
    logic [5:0]  mn;
    logic        tk;
    logic        md;
    logic [15:0] ed;
    logic        ep;
    logic        er;
    logic        ee;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [7:0] bcd2(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge, then settle away from the edge and release pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    load    = 1'b0;
    tick    = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    load = 1'b1; load_hr = h; load_min = m; load_sec = s;
    cyc();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
  endtask

  int pulses;
  int mins;

  initial begin
    reset_n = 1'b0; tick = 1'b0; load = 1'b0; mode_12h = 1'b0;
    load_hr = 5'd0; load_min = 6'd0; load_sec = 6'd0;

    //          rn    ld    hr     mn     tk    md    disp       pm    roll  err
    vecs[0]  = '{1'b0, 1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 5'd11, 6'd45, 1'b0, 1'b0, 16'h1145, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0,  6'd0,  1'b1, 1'b0, 16'h1146, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 5'd0,  6'd0,  1'b0, 1'b1, 16'h1146, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 5'd12, 6'd0,  1'b0, 1'b1, 16'h1200, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 5'd0,  6'd5,  1'b0, 1'b1, 16'h1205, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 5'd13, 6'd7,  1'b0, 1'b1, 16'h0107, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 5'd23, 6'd59, 1'b0, 1'b0, 16'h2359, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  6'd0,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 5'd24, 6'd10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 5'd0,  6'd60, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 5'd0,  6'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 5'd5,  6'd0,  1'b0, 1'b0, 16'h0500, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 5'd24, 6'd10, 1'b1, 1'b0, 16'h0500, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 5'd7,  6'd30, 1'b1, 1'b0, 16'h0730, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 5'd12, 6'd34, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 5'd1,  6'd1,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 5'd0,  6'd0,  1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      reset_n  = vecs[i].rn;
      load     = vecs[i].ld;
      load_hr  = vecs[i].hr;
      load_min = vecs[i].mn;
      load_sec = 6'd0;
      tick     = vecs[i].tk;
      mode_12h = vecs[i].md;
      cyc();
      chk($sformatf("vec%0d_disp", i), 32'(disp0), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_pm", i),   32'(pm0),   32'(vecs[i].ep));
      chk($sformatf("vec%0d_roll", i), 32'(roll0), 32'(vecs[i].er));
      chk($sformatf("vec%0d_err", i),  32'(err0),  32'(vecs[i].ee));
    end

    // Full day of minute ticks from reset, plus one.
    mode_12h = 1'b0;
    reset_n = 1'b0;
    cyc();
    pulses = 0;
    for (int i = 1; i <= 1441; i++) begin
      do_tick();
      mins = i % 1440;
      if (roll0) pulses++;
      chk($sformatf("day_tick%0d_disp", i), 32'(disp0),
          32'({bcd2(mins / 60), bcd2(mins % 60)}));
      chk($sformatf("day_tick%0d_roll", i), 32'(roll0), 32'(i == 1440));
    end
    chk("day_roll_pulses", 32'(pulses), 32'd1);

    // 121 ticks from 11:45, then a 12-hour view toggle.
    do_load(5'd11, 6'd45, 6'd0);
    for (int i = 0; i < 121; i++) do_tick();
    chk("run121_disp", 32'(disp0), 32'h1346);
    mode_12h = 1'b1;
    #1;
    chk("run121_12h_disp", 32'(disp0), 32'h0146);
    chk("run121_12h_pm", 32'(pm0), 32'd1);
    cyc();
    mode_12h = 1'b0;
    #1;
    chk("run121_back24_disp", 32'(disp0), 32'h1346);

    // Seconds instance: day wrap through 23:59:59.
    do_load(5'd23, 6'd59, 6'd58);
    chk("sec_load_disp", 32'(disp1), 32'h235958);
    do_tick();
    chk("sec_t1_disp", 32'(disp1), 32'h235959);
    chk("sec_t1_roll", 32'(roll1), 32'd0);
    do_tick();
    chk("sec_t2_disp", 32'(disp1), 32'h000000);
    chk("sec_t2_roll", 32'(roll1), 32'd1);
    chk("sec_t2_pm", 32'(pm1), 32'd0);
    cyc();
    chk("sec_idle_roll", 32'(roll1), 32'd0);

    // Seconds field validation differs between the two instances.
    do_load(5'd10, 6'd20, 6'd60);
    chk("sec60_err_sec", 32'(err1), 32'd1);
    chk("sec60_disp_sec", 32'(disp1), 32'h000000);
    chk("sec60_err_nosec", 32'(err0), 32'd0);
    chk("sec60_disp_nosec", 32'(disp0), 32'h1020);

    mode_12h = 1'b1;
    do_load(5'd0, 6'd0, 6'd7);
    chk("sec_12h_midnight", 32'(disp1), 32'h120007);
    chk("sec_load_zero_roll", 32'(roll1), 32'd0);
    do_load(5'd18, 6'd9, 6'd30);
    chk("sec_12h_pm_disp", 32'(disp1), 32'h060930);
    chk("sec_12h_pm", 32'(pm1), 32'd1);
    mode_12h = 1'b0;
    #1;
    chk("sec_24h_disp", 32'(disp1), 32'h180930);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
